guess_sweep_ctrl: RTL and testbench



---
 rtl/guess_sweep_pkg.sv | 27 ++
 rtl/guess_sweep_ctrl_if.sv | 21 ++
 rtl/guess_sweep_ctrl_sample_accum.sv | 62 ++++++
 rtl/guess_sweep_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_guess_sweep_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/guess_sweep_pkg.sv
// Shared types and protocol constants for the guess sweep scheduler,
// the top-level sequencer and the send_guess transaction engine.
package guess_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    MEASURE = 3'd2,
    ACCUM   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } sweep_state_t;

  // Protocol bytes exchanged with the MCU; candidates start right after them.
  localparam logic [7:0] START_BYTE        = 8'h01;
  localparam logic [7:0] ACK_BYTE          = 8'h02;
  localparam logic [7:0] YES_BYTE          = 8'h03;
  localparam logic [7:0] NO_BYTE           = 8'h04;
  localparam logic [7:0] END_BYTE          = 8'h05;
  localparam logic [7:0] START_GUESS_RANGE = 8'h06;

  // Sum width that cannot overflow with SAMPLES saturated delays.
  function automatic int sum_width(input int cnt_w, input int samples);
    return cnt_w + $clog2(samples);
  endfunction

endpackage

// File: rtl/guess_sweep_ctrl_if.sv
// Handshake between the sweep controller (master) and send_guess (slave).
interface guess_sweep_ctrl_if;
  logic [7:0] guess_byte;
  logic       begin_transaction;
  logic       waiting_for_reply;
  logic       correct_flag;

  modport master (
    output guess_byte,
    output begin_transaction,
    input  waiting_for_reply,
    input  correct_flag
  );

  modport slave (
    input  guess_byte,
    input  begin_transaction,
    output waiting_for_reply,
    output correct_flag
  );
endinterface

// File: rtl/guess_sweep_ctrl_sample_accum.sv
// Per-candidate delay measurement: saturating reply-delay counter and
// running sum. With GUESS_SWEEP_TRIM_EN defined it also tracks the largest
// single sample so the compared value drops one outlier (needs SAMPLES >= 2).
module sample_accum #(
  parameter int CNT_W = 24,
  parameter int SUM_W = 26
) (
  input  logic             CLK_50,
  input  logic             RST_N,
  input  logic             clr_cnt,
  input  logic             inc,
  input  logic             add,
  input  logic             clr_sum,
  output logic [SUM_W-1:0] cmp_sum
);

  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] sum_q;

  // Delay counter: cleared per sample, holds at all-ones instead of wrapping.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Running sum of the samples of the current candidate.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sum_q <= '0;
    end else if (clr_sum) begin
      sum_q <= '0;
    end else if (add) begin
      sum_q <= sum_q + SUM_W'(cnt_q);
    end
  end

`ifdef GUESS_SWEEP_TRIM_EN
  logic [CNT_W-1:0] max_q;

  // Largest single sample of the current candidate.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      max_q <= '0;
    end else if (clr_sum) begin
      max_q <= '0;
    end else if (add && (cnt_q > max_q)) begin
      max_q <= cnt_q;
    end
  end

  // max_q is one of the summed samples, so this never underflows.
  assign cmp_sum = sum_q - SUM_W'(max_q);
`else
  assign cmp_sum = sum_q;
`endif

endmodule

// File: rtl/guess_sweep_ctrl.sv
// Sweep scheduler for one code-byte position: walks candidates
// FIRST_GUESS..LAST_GUESS, runs SAMPLES send_guess transactions each,
// and keeps the candidate with the largest summed reply delay.
// Optional build macro: GUESS_SWEEP_TRIM_EN (compare sum minus largest sample).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// ISSUE   | begin_transaction high, delay counter cleared
// MEASURE | counting cycles with waiting_for_reply high
// ACCUM   | add sample delay to the candidate sum
// COMPARE | update best candidate, advance or finish
// DONE    | one-cycle done pulse
module guess_sweep_ctrl
  import guess_sweep_pkg::*;
#(
  parameter int         SAMPLES     = 4,
  parameter int         CNT_W       = 24,
  parameter logic [7:0] FIRST_GUESS = START_GUESS_RANGE,
  parameter logic [7:0] LAST_GUESS  = 8'hFF,
  localparam int        SUM_W       = CNT_W + $clog2(SAMPLES)
) (
  input  logic                   CLK_50,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             best_byte,
  output logic [SUM_W-1:0]       best_sum,
  output logic                   correct,
  guess_sweep_ctrl_if.master     sg
);

  localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  sweep_state_t     state_q, state_d;
  logic [7:0]       guess_q;
  logic [IDX_W-1:0] sample_idx;
  logic [7:0]       best_byte_q;
  logic [SUM_W-1:0] best_sum_q;
  logic             correct_q;
  logic [SUM_W-1:0] cmp_sum;

  logic clr_cnt, inc, add, clr_sum;
  logic load_first, next_sample, next_cand;
  logic take_best, take_correct, clear_results;
  logic last_sample, last_cand, in_sweep;

  assign last_sample = (sample_idx == IDX_W'(SAMPLES - 1));
  assign last_cand   = (guess_q == LAST_GUESS);
  assign in_sweep    = (state_q != IDLE) && (state_q != DONE);

  sample_accum #(
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_accum (
    .CLK_50  (CLK_50),
    .RST_N   (RST_N),
    .clr_cnt (clr_cnt),
    .inc     (inc),
    .add     (add),
    .clr_sum (clr_sum),
    .cmp_sum (cmp_sum)
  );

  // State register.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; correct_flag ends the sweep, abort beats everything.
  always_comb begin
    state_d       = state_q;
    clr_cnt       = 1'b0;
    inc           = 1'b0;
    add           = 1'b0;
    clr_sum       = 1'b0;
    load_first    = 1'b0;
    next_sample   = 1'b0;
    next_cand     = 1'b0;
    take_best     = 1'b0;
    take_correct  = 1'b0;
    clear_results = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = ISSUE;
          load_first    = 1'b1;
          clr_sum       = 1'b1;
          clear_results = 1'b1;
        end
      end
      ISSUE: begin
        clr_cnt = 1'b1;
        if (sg.waiting_for_reply) state_d = MEASURE;
      end
      MEASURE: begin
        if (sg.waiting_for_reply) inc = 1'b1;
        else                      state_d = ACCUM;
      end
      ACCUM: begin
        add = 1'b1;
        if (last_sample) begin
          state_d = COMPARE;
        end else begin
          next_sample = 1'b1;
          state_d     = ISSUE;
        end
      end
      COMPARE: begin
        take_best = (cmp_sum > best_sum_q);
        if (last_cand) begin
          state_d = DONE;
        end else begin
          next_cand = 1'b1;
          clr_sum   = 1'b1;
          state_d   = ISSUE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The acknowledged candidate wins outright; best_sum keeps its value.
    if (sg.correct_flag && in_sweep) begin
      state_d      = DONE;
      take_correct = 1'b1;
      take_best    = 1'b0;
      next_sample  = 1'b0;
      next_cand    = 1'b0;
      clr_sum      = 1'b0;
    end

    if (abort) begin
      state_d       = IDLE;
      clr_cnt       = 1'b0;
      inc           = 1'b0;
      add           = 1'b0;
      clr_sum       = 1'b0;
      load_first    = 1'b0;
      next_sample   = 1'b0;
      next_cand     = 1'b0;
      take_best     = 1'b0;
      take_correct  = 1'b0;
      clear_results = 1'b0;
    end
  end

  // Candidate and sample counters; LAST_GUESS is caught before any increment.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      guess_q    <= FIRST_GUESS;
      sample_idx <= '0;
    end else begin
      if (load_first)     guess_q <= FIRST_GUESS;
      else if (next_cand) guess_q <= guess_q + 8'd1;

      if (load_first || next_cand) sample_idx <= '0;
      else if (next_sample)        sample_idx <= sample_idx + 1'b1;
    end
  end

  // Result registers; ties keep the earlier, lower candidate.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      best_byte_q <= 8'h00;
      best_sum_q  <= '0;
      correct_q   <= 1'b0;
    end else if (clear_results) begin
      best_byte_q <= 8'h00;
      best_sum_q  <= '0;
      correct_q   <= 1'b0;
    end else if (take_correct) begin
      best_byte_q <= guess_q;
      correct_q   <= 1'b1;
    end else if (take_best) begin
      best_byte_q <= guess_q;
      best_sum_q  <= cmp_sum;
    end
  end

  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign best_byte            = best_byte_q;
  assign best_sum             = best_sum_q;
  assign correct              = correct_q;
  assign sg.guess_byte        = guess_q;
  assign sg.begin_transaction = (state_q == ISSUE);

endmodule

// File: tb/tb_guess_sweep_ctrl.sv
// Self-checking bench for guess_sweep_ctrl. Two instances:
//   A: SAMPLES=2, CNT_W=24, candidates FC..FF
//   B: SAMPLES=4, CNT_W=8,  candidates FC..FD (trim and saturation cases)
// Expected results follow GUESS_SWEEP_TRIM_EN when it is defined.
module tb_guess_sweep_ctrl;

`ifdef GUESS_SWEEP_TRIM_EN
  localparam bit TRIM = 1'b1;
`else
  localparam bit TRIM = 1'b0;
`endif

  logic CLK_50 = 1'b0;
  logic RST_N  = 1'b0;
  always #10 CLK_50 = ~CLK_50;

  logic        start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic        busy_a, done_a, cor_a, busy_b, done_b, cor_b;
  logic [7:0]  bb_a, bb_b;
  logic [25:0] bs_a;
  logic [9:0]  bs_b;

  guess_sweep_ctrl_if if_a ();
  guess_sweep_ctrl_if if_b ();

  guess_sweep_ctrl #(
    .SAMPLES(2), .CNT_W(24), .FIRST_GUESS(8'hFC), .LAST_GUESS(8'hFF)
  ) dut_a (
    .CLK_50(CLK_50), .RST_N(RST_N), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .best_byte(bb_a), .best_sum(bs_a),
    .correct(cor_a), .sg(if_a.master)
  );

  guess_sweep_ctrl #(
    .SAMPLES(4), .CNT_W(8), .FIRST_GUESS(8'hFC), .LAST_GUESS(8'hFD)
  ) dut_b (
    .CLK_50(CLK_50), .RST_N(RST_N), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .best_byte(bb_b), .best_sum(bs_b),
    .correct(cor_b), .sg(if_b.master)
  );

  int total = 0;
  int bad   = 0;
  int unsigned dly [4][4];

  typedef struct packed {
    logic [7:0]  d0, d1, d2, d3;
    logic [7:0]  exp_byte;
    logic [31:0] exp_raw;
    logic [31:0] exp_trim;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic get_begin(input int u);
    return (u == 0) ? if_a.begin_transaction : if_b.begin_transaction;
  endfunction
  function automatic logic get_done(input int u);
    return (u == 0) ? done_a : done_b;
  endfunction
  function automatic logic get_busy(input int u);
    return (u == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_cor(input int u);
    return (u == 0) ? cor_a : cor_b;
  endfunction
  function automatic logic [31:0] get_guess(input int u);
    return (u == 0) ? 32'(if_a.guess_byte) : 32'(if_b.guess_byte);
  endfunction
  function automatic logic [31:0] get_bb(input int u);
    return (u == 0) ? 32'(bb_a) : 32'(bb_b);
  endfunction
  function automatic logic [31:0] get_bs(input int u);
    return (u == 0) ? 32'(bs_a) : 32'(bs_b);
  endfunction

  task automatic set_wait(input int u, input logic v);
    if (u == 0) if_a.waiting_for_reply = v; else if_b.waiting_for_reply = v;
  endtask
  task automatic set_corr(input int u, input logic v);
    if (u == 0) if_a.correct_flag = v; else if_b.correct_flag = v;
  endtask
  task automatic set_start(input int u, input logic v);
    if (u == 0) start_a = v; else start_b = v;
  endtask
  task automatic set_abort(input int u, input logic v);
    if (u == 0) abort_a = v; else abort_b = v;
  endtask

  // Runs a sweep acting as send_guess. A reply of N cycles holds
  // waiting_for_reply for N+1 cycles: the first is the ISSUE hand-off.
  // stop_mode at (stop_c, stop_s): 0 abort, 1 correct_flag, 2 leave in MEASURE.
  task automatic run_sweep(input int u, input int nc, input int ns,
                           input int stop_c, input int stop_s, input int stop_mode,
                           output int hs);
    int n;
    int overlap;
    hs = 0;
    overlap = 0;
    set_start(u, 1'b1);
    @(negedge CLK_50);
    set_start(u, 1'b0);
    chk("start_to_begin", 32'(get_begin(u)), 32'd1);
    chk("busy_after_start", 32'(get_busy(u)), 32'd1);
    chk("bs_cleared_on_start", get_bs(u), 32'd0);
    chk("bb_cleared_on_start", get_bb(u), 32'd0);
    for (int c = 0; c < nc; c++) begin
      for (int s = 0; s < ns; s++) begin
        n = 0;
        while (!get_begin(u) && n < 100) begin
          @(negedge CLK_50);
          n++;
        end
        if (n >= 100) begin
          chk("begin_timeout", 32'(n), 32'd0);
          return;
        end
        hs++;
        chk("guess_byte", get_guess(u), 32'hFC + 32'(c));
        set_wait(u, 1'b1);
        if (c == stop_c && s == stop_s) begin
          @(negedge CLK_50);
          if (stop_mode == 2) return;
          if (stop_mode == 0) set_abort(u, 1'b1);
          else                set_corr(u, 1'b1);
          @(negedge CLK_50);
          set_abort(u, 1'b0);
          set_corr(u, 1'b0);
          set_wait(u, 1'b0);
          return;
        end
        repeat (dly[c][s] + 1) begin
          @(negedge CLK_50);
          if (get_begin(u)) overlap++;
        end
        set_wait(u, 1'b0);
      end
    end
    chk("begin_while_waiting", 32'(overlap), 32'd0);
  endtask

  task automatic wait_done(input int u, output int cyc);
    cyc = 0;
    while (!get_done(u) && cyc < 50) begin
      @(negedge CLK_50);
      cyc++;
    end
  endtask

  task automatic set_uniform(input int c, input int v);
    for (int s = 0; s < 4; s++) dly[c][s] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, cyc, nb, nd;
    logic [31:0] exp_sum;

    vecs[0] = '{8'd10, 8'd10, 8'd30, 8'd10, 8'hFE, 32'd60, 32'd30};
    vecs[1] = '{8'd12, 8'd12, 8'd12, 8'd12, 8'hFC, 32'd24, 32'd12};
    vecs[2] = '{8'd5,  8'd40, 8'd40, 8'd7,  8'hFD, 32'd80, 32'd40};
    vecs[3] = '{8'd3,  8'd4,  8'd5,  8'd6,  8'hFF, 32'd12, 32'd6};
    vecs[4] = '{8'd0,  8'd0,  8'd0,  8'd0,  8'h00, 32'd0,  32'd0};

    if_a.waiting_for_reply = 1'b0; if_a.correct_flag = 1'b0;
    if_b.waiting_for_reply = 1'b0; if_b.correct_flag = 1'b0;

    // Reset values.
    repeat (2) @(negedge CLK_50);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_correct", 32'(cor_a), 32'd0);
    chk("rst_best_byte", 32'(bb_a), 32'd0);
    chk("rst_best_sum", 32'(bs_a), 32'd0);
    chk("rst_guess_byte", 32'(if_a.guess_byte), 32'hFC);
    chk("rst_begin", 32'(if_a.begin_transaction), 32'd0);
    chk("rst_guess_byte_b", 32'(if_b.guess_byte), 32'hFC);
    RST_N = 1'b1;
    @(negedge CLK_50);
    chk("idle_busy", 32'(busy_a), 32'd0);

    // Table-driven sweeps on instance A.
    for (int i = 0; i < 5; i++) begin
      set_uniform(0, int'(vecs[i].d0));
      set_uniform(1, int'(vecs[i].d1));
      set_uniform(2, int'(vecs[i].d2));
      set_uniform(3, int'(vecs[i].d3));
      exp_sum = TRIM ? vecs[i].exp_trim : vecs[i].exp_raw;
      run_sweep(0, 4, 2, -1, -1, 0, hs);
      wait_done(0, cyc);
      chk("done_latency", 32'(cyc), 32'd3);
      chk("vec_best_byte", get_bb(0), 32'(vecs[i].exp_byte));
      chk("vec_best_sum", get_bs(0), exp_sum);
      chk("vec_correct", 32'(cor_a), 32'd0);
      chk("vec_handshakes", 32'(hs), 32'd8);
      @(negedge CLK_50);
      chk("done_one_cycle", 32'(done_a), 32'd0);
      chk("busy_after_done", 32'(busy_a), 32'd0);
      chk("result_held", get_bb(0), 32'(vecs[i].exp_byte));
    end

    // Early correct during the 2nd sample of FD.
    for (int c = 0; c < 4; c++) set_uniform(c, 10);
    run_sweep(0, 4, 2, 1, 1, 1, hs);
    wait_done(0, cyc);
    chk("corr_done_latency", 32'(cyc), 32'd0);
    chk("corr_correct", 32'(cor_a), 32'd1);
    chk("corr_best_byte", get_bb(0), 32'hFD);
    chk("corr_best_sum_held", get_bs(0), TRIM ? 32'd10 : 32'd20);
    chk("corr_handshakes", 32'(hs), 32'd4);
    nb = 0; nd = 0;
    repeat (10) begin
      @(negedge CLK_50);
      nb += int'(if_a.begin_transaction);
      nd += int'(done_a);
    end
    chk("corr_no_more_begin", 32'(nb), 32'd0);
    chk("corr_single_done", 32'(nd), 32'd0);

    // Abort mid-MEASURE of FD, then a fresh basic sweep.
    run_sweep(0, 4, 2, 1, 0, 0, hs);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    nb = 0; nd = 0;
    repeat (10) begin
      @(negedge CLK_50);
      nb += int'(if_a.begin_transaction);
      nd += int'(done_a);
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_no_begin", 32'(nb), 32'd0);
    chk("abort_bb_held", get_bb(0), 32'hFC);
    chk("abort_bs_held", get_bs(0), TRIM ? 32'd10 : 32'd20);
    set_uniform(2, 30);
    run_sweep(0, 4, 2, -1, -1, 0, hs);
    wait_done(0, cyc);
    chk("post_abort_done", 32'(done_a), 32'd1);
    chk("post_abort_bb", get_bb(0), 32'hFE);
    chk("post_abort_bs", get_bs(0), TRIM ? 32'd30 : 32'd60);
    chk("post_abort_hs", 32'(hs), 32'd8);
    @(negedge CLK_50);

    // Simultaneous start and abort in IDLE: start is dropped.
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge CLK_50);
    start_a = 1'b0; abort_a = 1'b0;
    chk("start_abort_busy", 32'(busy_a), 32'd0);
    chk("start_abort_begin", 32'(if_a.begin_transaction), 32'd0);

    // Instance B: outlier trimming.
    for (int s = 0; s < 4; s++) dly[0][s] = 10;
    dly[0][3] = 200;
    set_uniform(1, 20);
    run_sweep(1, 2, 4, -1, -1, 0, hs);
    wait_done(1, cyc);
    chk("trim_done_latency", 32'(cyc), 32'd3);
    chk("trim_best_byte", get_bb(1), TRIM ? 32'hFD : 32'hFC);
    chk("trim_best_sum", get_bs(1), TRIM ? 32'd60 : 32'd230);
    chk("trim_handshakes", 32'(hs), 32'd8);
    @(negedge CLK_50);

    // Instance B: 8-bit counter saturates at 255, sum keeps the carry.
    dly[0][0] = 300; dly[0][1] = 1; dly[0][2] = 1; dly[0][3] = 1;
    set_uniform(1, 5);
    run_sweep(1, 2, 4, -1, -1, 0, hs);
    wait_done(1, cyc);
    chk("sat_done", 32'(done_b), 32'd1);
    chk("sat_best_byte", get_bb(1), TRIM ? 32'hFD : 32'hFC);
    chk("sat_best_sum", get_bs(1), TRIM ? 32'd15 : 32'd258);
    chk("sat_correct", 32'(cor_b), 32'd0);
    @(negedge CLK_50);

    // Asynchronous reset in the middle of a measurement.
    for (int c = 0; c < 4; c++) set_uniform(c, 10);
    run_sweep(0, 4, 2, 1, 0, 2, hs);
    chk("pre_reset_busy", 32'(busy_a), 32'd1);
    #3 RST_N = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    chk("async_rst_guess", 32'(if_a.guess_byte), 32'hFC);
    chk("async_rst_bb", 32'(bb_a), 32'd0);
    chk("async_rst_bs", 32'(bs_a), 32'd0);
    set_wait(0, 1'b0);
    @(negedge CLK_50);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK_50);
    chk("post_rst_idle", 32'(busy_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
